// File: rtl/io_read_sched.sv
// IO read sequencer: decodes the IO read address to one of NDev input devices, runs a req/ack
// handshake with it and stalls the CPU until data (or a timeout/bad-address error) comes back.
module io_read_sched #(
  parameter int unsigned     NDev    = 4,
  parameter int unsigned     Dw      = 16,
  parameter int unsigned     Timeout = 16,
  parameter logic [Dw-1:0]   ErrData = Dw'(16'hDEAD)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ior_i,
  input  logic [7:0]         io_addr_i,
  output logic [Dw-1:0]      io_rdata_o,
  output logic               io_valid_o,
  output logic               io_err_o,
  output logic               io_stall_o,
  output logic               dev_req_o,
  output logic [NDev-1:0]    dev_sel_o,
  input  logic [NDev-1:0]    dev_ack_i,
  input  logic [NDev*Dw-1:0] dev_data_i
);

  localparam int unsigned IdxW = (NDev > 1) ? $clog2(NDev) : 1;
  localparam int unsigned TmrW = $clog2(Timeout);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StDone,
    StErr,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [Dw-1:0]     rdata_q, rdata_d;

  logic [3:0]        addr_idx;
  logic              addr_ok;
  logic              sel_ack;
  logic [Dw-1:0]     sel_data;
  logic              unused_addr;

  assign addr_idx    = io_addr_i[7:4];
  assign addr_ok     = 32'(addr_idx) < NDev;
  assign unused_addr = ^io_addr_i[3:0];

  // Only the captured device's ack/data lane is ever looked at.
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NDev; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_ack  = dev_ack_i[i];
        sel_data = dev_data_i[i*Dw +: Dw];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers tracking the access in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q   <= '0;
      timer_q <= '0;
      rdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (ior_i) begin
          if (addr_ok) begin
            idx_d   = IdxW'(addr_idx);
            timer_d = '0;
            state_d = StReq;
          end else begin
            rdata_d = ErrData;
            state_d = StErr;
          end
        end
      end
      StReq: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (sel_ack) begin
          rdata_d = sel_data;
          state_d = StDone;
        end else if (timer_q == TmrW'(Timeout - 1)) begin
          rdata_d = ErrData;
          state_d = StErr;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StDone, StErr: begin
        state_d = StHold;
      end
      StHold: begin
        // Wait for the Controller to release ior so one strobe means one access.
        if (!ior_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    io_valid_o = (state_q == StDone) || (state_q == StErr);
    io_err_o   = (state_q == StErr);
    dev_req_o  = (state_q == StReq);
    io_stall_o = ((state_q == StIdle) && ior_i) || (state_q == StReq);
    for (int unsigned i = 0; i < NDev; i++) begin
      dev_sel_o[i] = (state_q == StReq) && (idx_q == IdxW'(i));
    end
  end

  assign io_rdata_o = rdata_q;

`ifndef SYNTHESIS
  a_valid_pulse : assert property (@(posedge clk_i) disable iff (reset_i)
    io_valid_o |=> !io_valid_o);
  a_sel_onehot : assert property (@(posedge clk_i) disable iff (reset_i)
    dev_req_o |-> $onehot(dev_sel_o));
  a_rdata_stable : assert property (@(posedge clk_i) disable iff (reset_i)
    !(state_d inside {StDone, StErr}) |=> $stable(io_rdata_o));
`endif

endmodule

// File: tb/tb_io_read_sched.sv
// Bench for io_read_sched: directed table, reset-in-flight sequence and randomized accesses,
// all checked against a transaction-level timeline model.
module tb_io_read_sched;

  localparam int unsigned NDev    = 4;
  localparam int unsigned Dw      = 16;
  localparam int unsigned Timeout = 16;
  localparam logic [15:0] ErrData = 16'hDEAD;
  localparam int          Never   = 1000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ior_i;
  logic [7:0]  io_addr_i;
  logic [15:0] io_rdata_o;
  logic        io_valid_o;
  logic        io_err_o;
  logic        io_stall_o;
  logic        dev_req_o;
  logic [3:0]  dev_sel_o;
  logic [3:0]  dev_ack_i;
  logic [63:0] dev_data_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_rdata;

  typedef struct {
    logic [7:0]  addr;
    int          k;
    bit          tie;
    logic [15:0] data;
    int          drop_at;
    int          hold_extra;
    bit          noise;
  } vec_t;

  vec_t tbl[9];

  io_read_sched #(
    .NDev    (NDev),
    .Dw      (Dw),
    .Timeout (Timeout),
    .ErrData (ErrData)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .ior_i      (ior_i),
    .io_addr_i  (io_addr_i),
    .io_rdata_o (io_rdata_o),
    .io_valid_o (io_valid_o),
    .io_err_o   (io_err_o),
    .io_stall_o (io_stall_o),
    .dev_req_o  (dev_req_o),
    .dev_sel_o  (dev_sel_o),
    .dev_ack_i  (dev_ack_i),
    .dev_data_i (dev_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One complete access: ior raised in IDLE at cycle c=0, device ack at c=k (k=0: never).
  task automatic run_access(input logic [7:0] addr, input int k, input bit tie,
                            input logic [15:0] data, input int drop_at, input int hold_extra,
                            input bit noise, input string tag);
    int          idx;
    int          ack_at;
    int          lat;
    bit          exp_err;
    bit          exp_req;
    logic [15:0] exp_data;
    logic [15:0] prev;
    logic [3:0]  ack;
    logic [3:0]  exp_sel;
    idx    = int'(addr[7:4]);
    ack_at = tie ? 1 : k;
    if (idx >= int'(NDev)) begin
      lat = 1; exp_err = 1'b1; exp_data = ErrData;
    end else if (ack_at >= 1 && ack_at <= int'(Timeout)) begin
      lat = ack_at + 1; exp_err = 1'b0; exp_data = data;
    end else begin
      lat = int'(Timeout) + 1; exp_err = 1'b1; exp_data = ErrData;
    end
    prev = model_rdata;
    for (int i = 0; i < int'(NDev); i++) dev_data_i[i*Dw +: Dw] = 16'($urandom);
    if (idx < int'(NDev)) dev_data_i[idx*Dw +: Dw] = data;

    for (int c = 0; c <= lat; c++) begin
      ior_i     = (c < drop_at);
      io_addr_i = (c == 0) ? addr : 8'($urandom);
      ack       = noise ? 4'($urandom) : 4'b0000;
      if (idx < int'(NDev)) ack[idx] = tie || (c == ack_at);
      dev_ack_i = ack;
      @(negedge clk_i);
      exp_req = (c >= 1) && (c < lat);
      exp_sel = exp_req ? (4'b0001 << idx) : 4'b0000;
      chk($sformatf("%s c%0d io_valid", tag, c), 32'(io_valid_o), 32'(c == lat));
      chk($sformatf("%s c%0d io_stall", tag, c), 32'(io_stall_o), 32'(c < lat));
      chk($sformatf("%s c%0d dev_req", tag, c), 32'(dev_req_o), 32'(exp_req));
      chk($sformatf("%s c%0d dev_sel", tag, c), 32'(dev_sel_o), 32'(exp_sel));
      chk($sformatf("%s c%0d io_rdata", tag, c), 32'(io_rdata_o),
          32'((c == lat) ? exp_data : prev));
      if (c == lat) chk($sformatf("%s io_err", tag), 32'(io_err_o), 32'(exp_err));
      next_cycle();
    end
    model_rdata = exp_data;

    // Controller keeps ior high a while, then releases it; nothing may restart meanwhile.
    for (int c = 0; c <= hold_extra; c++) begin
      ior_i     = (c < hold_extra);
      io_addr_i = 8'($urandom);
      dev_ack_i = noise ? 4'($urandom) : 4'b0000;
      @(negedge clk_i);
      chk($sformatf("%s hold%0d io_valid", tag, c), 32'(io_valid_o), 32'(0));
      chk($sformatf("%s hold%0d dev_req", tag, c), 32'(dev_req_o), 32'(0));
      chk($sformatf("%s hold%0d io_stall", tag, c), 32'(io_stall_o), 32'(0));
      chk($sformatf("%s hold%0d io_rdata", tag, c), 32'(io_rdata_o), 32'(model_rdata));
      next_cycle();
    end
    dev_ack_i = 4'b0000;
  endtask

  initial begin
    tbl[0] = '{8'h05, 1,  1'b1, 16'h00A5, Never, 0, 1'b0};  // zero-wait device
    tbl[1] = '{8'h2C, 3,  1'b0, 16'h1234, Never, 1, 1'b0};  // three REQ cycles
    tbl[2] = '{8'h70, 1,  1'b0, 16'h9999, Never, 0, 1'b0};  // bad address
    tbl[3] = '{8'h30, 0,  1'b0, 16'h4444, Never, 5, 1'b0};  // timeout, then ior held
    tbl[4] = '{8'h1F, 16, 1'b0, 16'hBEEF, Never, 0, 1'b1};  // ack on last allowed cycle
    tbl[5] = '{8'h20, 17, 1'b0, 16'h7777, Never, 2, 1'b1};  // ack one cycle too late
    tbl[6] = '{8'h3A, 5,  1'b0, 16'h5A5A, 2,     0, 1'b1};  // ior dropped during REQ
    tbl[7] = '{8'h00, 2,  1'b0, 16'h0F0F, Never, 1, 1'b1};  // foreign acks present
    tbl[8] = '{8'hF1, 1,  1'b0, 16'h1111, Never, 3, 1'b1};  // bad address, top index

    reset_i    = 1'b1;
    ior_i      = 1'b0;
    io_addr_i  = 8'h00;
    dev_ack_i  = 4'b0000;
    dev_data_i = '0;
    model_rdata = 16'h0000;
    @(negedge clk_i);
    chk("reset io_valid", 32'(io_valid_o), 32'(0));
    chk("reset io_err", 32'(io_err_o), 32'(0));
    chk("reset dev_req", 32'(dev_req_o), 32'(0));
    chk("reset dev_sel", 32'(dev_sel_o), 32'(0));
    chk("reset io_rdata", 32'(io_rdata_o), 32'(0));
    chk("reset io_stall", 32'(io_stall_o), 32'(0));
    next_cycle();
    reset_i = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_access(tbl[v].addr, tbl[v].k, tbl[v].tie, tbl[v].data, tbl[v].drop_at,
                 tbl[v].hold_extra, tbl[v].noise, $sformatf("vec%0d", v));
    end

    // Reset while device 1 is being requested.
    ior_i      = 1'b1;
    io_addr_i  = 8'h10;
    dev_ack_i  = 4'b0000;
    @(negedge clk_i);
    chk("rst-mid stall idle", 32'(io_stall_o), 32'(1));
    next_cycle();
    @(negedge clk_i);
    chk("rst-mid dev_sel", 32'(dev_sel_o), 32'(4'b0010));
    next_cycle();
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst-mid dev_req before edge", 32'(dev_req_o), 32'(1));
    next_cycle();
    reset_i = 1'b0;
    ior_i   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("rst-mid c%0d dev_req", c), 32'(dev_req_o), 32'(0));
      chk($sformatf("rst-mid c%0d io_valid", c), 32'(io_valid_o), 32'(0));
      chk($sformatf("rst-mid c%0d io_rdata", c), 32'(io_rdata_o), 32'(0));
      chk($sformatf("rst-mid c%0d io_stall", c), 32'(io_stall_o), 32'(0));
      next_cycle();
    end
    model_rdata = 16'h0000;

    for (int r = 0; r < 40; r++) begin
      logic [7:0] addr;
      int         k;
      bit         tie;
      int         drop_at;
      addr    = {4'($urandom_range(0, 5)), 4'($urandom)};
      k       = int'($urandom_range(0, 18));
      tie     = ($urandom_range(0, 7) == 0);
      drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : Never;
      run_access(addr, k, tie, 16'($urandom), drop_at, int'($urandom_range(0, 3)), 1'b1,
                 $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
